// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_word_packer
//  Purpose  : Reads IN_WIDTH-bit words from a FIFO and packs each pair into a
//             2*IN_WIDTH-bit output beat {hi, lo}. A lone low half can be
//             emitted zero-padded (m_odd=1) by raising flush while the FIFO
//             is empty and the packer is waiting for the high half.
//  Ports    :
//    clk           - single clock, rising edge
//    rst_n         - asynchronous active-low reset
//    i_fifo_dout   - FIFO read data, valid the cycle after o_fifo_ren
//    i_fifo_empty  - FIFO empty flag
//    i_flush       - emit a pending lone low half (level-sampled)
//    i_m_ready     - downstream ready
//    o_fifo_ren    - FIFO read enable (combinational)
//    o_m_data      - packed beat {hi, lo} (registered)
//    o_m_valid     - o_m_data valid (registered)
//    o_m_odd       - beat hi half is zero padding (registered)
//    o_beat_cnt    - count of accepted beats, wraps (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   i_fifo_dout,
  input  logic                  i_fifo_empty,
  input  logic                  i_flush,
  input  logic                  i_m_ready,
  output logic                  o_fifo_ren,
  output logic [2*IN_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  output logic                  o_m_odd,
  output logic [CNT_WIDTH-1:0]  o_beat_cnt
);

  localparam logic [2:0] c_REQ_LO = 3'd0;
  localparam logic [2:0] c_CAP_LO = 3'd1;
  localparam logic [2:0] c_REQ_HI = 3'd2;
  localparam logic [2:0] c_CAP_HI = 3'd3;
  localparam logic [2:0] c_OUT    = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [IN_WIDTH-1:0]   r_lo;
  logic [2*IN_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_odd;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;

  logic                  w_ren;
  logic                  w_cap_lo;
  logic                  w_load_full;
  logic                  w_load_odd;
  logic                  w_accept;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_REQ_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_REQ_LO: if (!i_fifo_empty) w_state_nxt = c_CAP_LO;
      c_CAP_LO: w_state_nxt = c_REQ_HI;
      c_REQ_HI: begin
        // Available data wins over flush: a waiting hi word is always read.
        if (!i_fifo_empty) begin
          w_state_nxt = c_CAP_HI;
        end else if (i_flush) begin
          w_state_nxt = c_OUT;
        end
      end
      c_CAP_HI: w_state_nxt = c_OUT;
      c_OUT:    if (i_m_ready) w_state_nxt = c_REQ_LO;
      default:  w_state_nxt = c_REQ_LO;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_ren       = 1'b0;
    w_cap_lo    = 1'b0;
    w_load_full = 1'b0;
    w_load_odd  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      c_REQ_LO: w_ren = !i_fifo_empty;
      c_CAP_LO: w_cap_lo = 1'b1;
      c_REQ_HI: begin
        w_ren      = !i_fifo_empty;
        w_load_odd = i_fifo_empty && i_flush;
      end
      c_CAP_HI: w_load_full = 1'b1;
      c_OUT:    w_accept = i_m_ready;
      default:  w_ren = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo       <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_odd    <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      if (w_cap_lo) begin
        r_lo <= i_fifo_dout;
      end
      if (w_load_full) begin
        r_m_data  <= {i_fifo_dout, r_lo};
        r_m_valid <= 1'b1;
        r_m_odd   <= 1'b0;
      end else if (w_load_odd) begin
        r_m_data  <= {{IN_WIDTH{1'b0}}, r_lo};
        r_m_valid <= 1'b1;
        r_m_odd   <= 1'b1;
      end else if (w_accept) begin
        // m_data deliberately left untouched after acceptance.
        r_m_valid  <= 1'b0;
        r_m_odd    <= 1'b0;
        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Read enable is gated by reset so it is low the instant rst_n drops.
  assign o_fifo_ren = w_ren && rst_n;
  assign o_m_data   = r_m_data;
  assign o_m_valid  = r_m_valid;
  assign o_m_odd    = r_m_odd;
  assign o_beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_word_packer
//  Purpose  : Self-checking bench for fifo_word_packer: FIFO model, beat
//             scoreboard, vector table, directed corner sequences and a
//             randomized pairing run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

  localparam int c_IW = 16;
  localparam int c_CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [c_IW-1:0] fifo_dout = '0;
  logic            fifo_empty;
  logic            flush;
  logic            m_ready;
  logic            fifo_ren;
  logic [2*c_IW-1:0] m_data;
  logic            m_valid;
  logic            m_odd;
  logic [c_CW-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_word_packer #(.IN_WIDTH(c_IW), .CNT_WIDTH(c_CW)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fifo_dout  (fifo_dout),
    .i_fifo_empty (fifo_empty),
    .i_flush      (flush),
    .i_m_ready    (m_ready),
    .o_fifo_ren   (fifo_ren),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .o_m_odd      (m_odd),
    .o_beat_cnt   (beat_cnt)
  );

  // ---------------- FIFO model: data appears the cycle after a read -------
  logic [c_IW-1:0] mem [0:4095];
  int wr_ptr  = 0;
  int rd_ptr  = 0;
  int ren_cnt = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      ren_cnt   <= ren_cnt + 1;
    end
  end

  // ---------------- expected-beat scoreboard ------------------------------
  typedef struct packed {
    logic [31:0] data;
    logic        odd;
  } beat_t;
  beat_t exp_q[$];
  beat_t mon_e;

  logic        prev_v = 1'b0;
  logic        prev_rdy = 1'b0;
  logic        prev_odd = 1'b0;
  logic [31:0] prev_data = '0;
  int          acc_total = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (fifo_ren || m_valid || m_odd || m_data != 32'h0 || beat_cnt != 4'h0) begin
        errors++;
        $display("FAIL reset_outputs: ren=%0b valid=%0b odd=%0b data=%h cnt=%0d, required all zero",
                 fifo_ren, m_valid, m_odd, m_data, beat_cnt);
      end
      prev_v    = 1'b0;
      acc_total = 0;
    end else begin
      checks++;
      if (fifo_ren && (m_valid || fifo_empty)) begin
        errors++;
        $display("FAIL ren_illegal: ren=1 with valid=%0b empty=%0b, required ren=0",
                 m_valid, fifo_empty);
      end
      if (prev_v && !prev_rdy) begin
        checks++;
        if (!m_valid || m_data !== prev_data || m_odd !== prev_odd) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%h odd=%0b, required valid=1 data=%h odd=%0b",
                   m_valid, m_data, m_odd, prev_data, prev_odd);
        end
      end
      if (prev_v && prev_rdy) begin
        acc_total++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: data=%h odd=%0b, required no beat", prev_data, prev_odd);
        end else begin
          mon_e = exp_q.pop_front();
          if (prev_data !== mon_e.data || prev_odd !== mon_e.odd) begin
            errors++;
            $display("FAIL beat_data: data=%h odd=%0b, required data=%h odd=%0b",
                     prev_data, prev_odd, mon_e.data, mon_e.odd);
          end
        end
        checks++;
        if (beat_cnt !== acc_total[3:0]) begin
          errors++;
          $display("FAIL beat_cnt: got %0d, required %0d", beat_cnt, acc_total[3:0]);
        end
        checks++;
        if (m_valid || m_odd || m_data !== prev_data) begin
          errors++;
          $display("FAIL after_accept: valid=%0b odd=%0b data=%h, required 0 0 %h",
                   m_valid, m_odd, m_data, prev_data);
        end
      end
      prev_v    = m_valid;
      prev_rdy  = m_ready;
      prev_data = m_data;
      prev_odd  = m_odd;
    end
  end

  // ---------------- helpers -----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [c_IW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic o);
    beat_t b;
    b.data = d;
    b.odd  = o;
    exp_q.push_back(b);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: m_valid stayed 0 for 200 cycles, required 1", name);
    end
  endtask

  task automatic wait_invalid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: m_valid stayed 1 for 200 cycles, required 0", name);
    end
  endtask

  // Pushes a lone word, lets it be read as the low half, then pulses flush
  // for one cycle while the packer waits on an empty FIFO for the high half.
  task automatic odd_seq(input logic [c_IW-1:0] w);
    int r0;
    bit ok;
    r0 = ren_cnt;
    tick();
    push(w);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ren_cnt != r0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL odd_read: ren_cnt=%0d, required %0d", ren_cnt, r0 + 1);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    bit          two;
    bit          fl;
    logic [31:0] exp_data;
    bit          exp_odd;
    int          exp_ren;
  } vec_t;
  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0;
    int  n;
    int  pushed;
    bit  ok;
    logic [3:0]  c0;
    logic [15:0] lo_pend;
    logic [15:0] w;

    vt[0] = '{16'h1111, 16'h2222, 1'b1, 1'b0, 32'h2222_1111, 1'b0, 2};
    vt[1] = '{16'h00AB, 16'h0000, 1'b0, 1'b1, 32'h0000_00AB, 1'b1, 1};
    vt[2] = '{16'h5A5A, 16'hA5A5, 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0, 2};
    vt[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 32'h0000_FFFF, 1'b0, 2};
    vt[4] = '{16'h0001, 16'h0000, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1};
    vt[5] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 32'h7FFF_8000, 1'b0, 2};

    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid || m_odd || m_data != 32'h0 || beat_cnt != 4'h0 || fifo_ren) begin
      errors++;
      $display("FAIL post_reset: valid=%0b odd=%0b data=%h cnt=%0d ren=%0b, required all zero",
               m_valid, m_odd, m_data, beat_cnt, fifo_ren);
    end

    // ---- table-driven vectors ----
    tick();
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r0 = ren_cnt;
      expect_beat(vt[k].exp_data, vt[k].exp_odd);
      if (vt[k].two) begin
        tick();
        flush = vt[k].fl;
        push(vt[k].lo);
        push(vt[k].hi);
      end else begin
        odd_seq(vt[k].lo);
      end
      wait_valid("vec_valid", ok);
      if (ok) begin
        checks++;
        if (m_data !== vt[k].exp_data || m_odd !== vt[k].exp_odd) begin
          errors++;
          $display("FAIL vec%0d: data=%h odd=%0b, required data=%h odd=%0b",
                   k, m_data, m_odd, vt[k].exp_data, vt[k].exp_odd);
        end
      end
      wait_invalid("vec_accept");
      tick();
      flush = 1'b0;
      checks++;
      if (ren_cnt - r0 != vt[k].exp_ren) begin
        errors++;
        $display("FAIL vec%0d_reads: got %0d, required %0d", k, ren_cnt - r0, vt[k].exp_ren);
      end
    end

    // ---- latency and minimum beat period ----
    tick();
    push(16'h0A0A); push(16'h0B0B); push(16'h0C0C); push(16'h0D0D);
    expect_beat(32'h0B0B_0A0A, 1'b0);
    expect_beat(32'h0D0D_0C0C, 1'b0);
    @(negedge clk);
    checks++;
    if (!fifo_ren) begin
      errors++;
      $display("FAIL lat_ren: ren=%0b, required 1", fifo_ren);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (m_valid) break;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL latency: %0d edges, required 4", n);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (m_valid) break;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL beat_period: %0d cycles, required 5", n);
    end
    wait_invalid("period_accept");

    // ---- backpressure ----
    tick();
    m_ready = 1'b0;
    push(16'h3333);
    push(16'h4444);
    expect_beat(32'h4444_3333, 1'b0);
    wait_valid("bp_valid", ok);
    r0 = ren_cnt;
    c0 = beat_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (ren_cnt != r0 || !m_valid || m_data !== 32'h4444_3333) begin
      errors++;
      $display("FAIL bp_hold: reads=%0d valid=%0b data=%h, required reads=0 valid=1 data=44443333",
               ren_cnt - r0, m_valid, m_data);
    end
    tick();
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (beat_cnt !== c0 + 4'd1) begin
      errors++;
      $display("FAIL bp_count: got %0d, required %0d", beat_cnt, c0 + 4'd1);
    end

    // ---- reset while a low half is held ----
    tick();
    r0 = ren_cnt;
    push(16'h1234);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ren_cnt != r0) break;
    end
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_ren || m_valid || m_odd || m_data != 32'h0 || beat_cnt != 4'h0) begin
      errors++;
      $display("FAIL midop_reset: ren=%0b valid=%0b odd=%0b data=%h cnt=%0d, required all zero",
               fifo_ren, m_valid, m_odd, m_data, beat_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    push(16'hBEEF);
    push(16'hCAFE);
    expect_beat(32'hCAFE_BEEF, 1'b0);
    wait_valid("rst_valid", ok);
    if (ok) begin
      checks++;
      if (m_data !== 32'hCAFE_BEEF || m_odd !== 1'b0) begin
        errors++;
        $display("FAIL rst_newdata: data=%h odd=%0b, required cafebeef 0", m_data, m_odd);
      end
    end
    wait_invalid("rst_accept");

    // ---- counter wrap: 17 beats from reset ----
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(16'(i * 2 + 16'h0100));
      push(16'(i * 2 + 16'h0101));
      expect_beat({16'(i * 2 + 16'h0101), 16'(i * 2 + 16'h0100)}, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(negedge clk);
    checks++;
    if (beat_cnt !== 4'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d pending=%0d, required 1 pending=0", beat_cnt, exp_q.size());
    end

    // ---- randomized pairing with random backpressure ----
    pushed = 0;
    lo_pend = '0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      m_ready = ($urandom_range(0, 2) != 0);
      if (pushed < 120 && $urandom_range(0, 1) == 1) begin
        w = 16'($urandom);
        push(w);
        if (pushed % 2 == 0) lo_pend = w;
        else expect_beat({w, lo_pend}, 1'b0);
        pushed++;
      end
      if (pushed >= 120 && exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d beats pending, required 0", exp_q.size());
    end
    tick();
    m_ready = 1'b1;
    wait_invalid("rand_idle");
    expect_beat(32'h0000_7E57, 1'b1);
    odd_seq(16'h7E57);
    wait_valid("rand_odd", ok);
    wait_invalid("rand_odd_accept");
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: %0d beats pending, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter IN_WIDTH, default 16, SHALL set the width of one FIFO read word.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of the beat counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 fifo_dout  input  IN_WIDTH  SHALL be the FIFO read data, valid the cycle after fifo_ren is sampled high.
REQ-006 fifo_empty  input  1  SHALL be the FIFO empty flag.
REQ-007 flush  input  1  SHALL request emission of a pending lone low half.
REQ-008 m_ready  input  1  SHALL be the downstream ready.
REQ-009 fifo_ren  output  1  SHALL be the FIFO read enable, combinational from state and fifo_empty.
REQ-010 m_data  output  2*IN_WIDTH  SHALL be the packed beat {hi, lo}, registered.
REQ-011 m_valid  output  1  SHALL mark m_data valid, registered.
REQ-012 m_odd  output  1  SHALL mark a flushed beat whose hi half is zero padding, registered.
REQ-013 beat_cnt  output  CNT_WIDTH  SHALL count accepted beats, registered.

Function
REQ-014 FSM states SHALL be REQ_LO, CAP_LO, REQ_HI, CAP_HI, OUT.
REQ-015 REQ_LO: fifo_ren = !fifo_empty; if fifo_empty is low, next state is CAP_LO, else stay.
REQ-016 CAP_LO: capture fifo_dout into lo register; next state is REQ_HI; fifo_ren is low.
REQ-017 REQ_HI: fifo_ren = !fifo_empty; if fifo_empty is low, next state is CAP_HI.
REQ-018 REQ_HI with fifo_empty high and flush high: load m_data = {0, lo}, set m_valid=1 and m_odd=1, next state is OUT.
REQ-019 REQ_HI with fifo_empty low SHALL read the hi word even if flush is high; flush is ignored there.
REQ-020 CAP_HI: load m_data = {fifo_dout, lo}, set m_valid=1 and m_odd=0, next state is OUT; fifo_ren is low.
REQ-021 OUT: fifo_ren is low; hold m_data, m_valid and m_odd stable while m_ready is low.
REQ-022 OUT with m_ready high: the beat is accepted; clear m_valid and m_odd, increment beat_cnt, and go to REQ_LO.
REQ-023 beat_cnt SHALL wrap modulo 2^CNT_WIDTH without saturation.
REQ-024 flush in REQ_LO, CAP_LO, CAP_HI or OUT SHALL have no effect; flush is level-sampled, not latched.
REQ-025 fifo_ren SHALL never be high in CAP_LO, CAP_HI or OUT.
REQ-026 Each accepted beat SHALL consume exactly two FIFO reads, or one read if m_odd=1.
REQ-027 Latency: from fifo_ren high in REQ_LO with data continuously available, m_valid SHALL rise 4 clock edges later.
REQ-028 Minimum beat period SHALL be 5 cycles when m_ready is held high.
REQ-029 m_data SHALL keep its last value after acceptance until it is reloaded.

Reset
REQ-030 When rst_n is low, the block SHALL immediately enter state REQ_LO and clear m_data, m_valid, m_odd, beat_cnt and lo to 0.
REQ-031 While rst_n is low, fifo_ren SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard any captured half word with no beat emitted.

Verification
REQ-033 FIFO preloaded with 0x1111, 0x2222 and m_ready=1 -> one beat m_data=0x2222_1111, m_odd=0, beat_cnt=1, and exactly 2 fifo_ren pulses.
REQ-034 m_ready=0 for 10 cycles during OUT -> m_data and m_valid stable with no fifo_ren; m_ready=1 -> beat_cnt increments once.
REQ-035 FIFO holds only 0x00AB, then flush pulse in REQ_HI -> m_data=0x0000_00AB, m_odd=1, 1 fifo_ren pulse total.
REQ-036 flush high while FIFO non-empty in REQ_HI -> normal beat with m_odd=0; flush ignored.
REQ-037 rst_n pulsed low in REQ_HI after capturing 0x1234 -> all outputs 0; the next beat uses only new data.
REQ-038 CNT_WIDTH=4 with 17 accepted beats -> beat_cnt wraps to 1.
